// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the serialising FIFO's byte write port among NUM_REQ producers.
// Write latency 1 cycle after handshake; ready drops on credit exhaustion (level == DEPTH), grant held.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 32,
    parameter int LVL_W     = 6,
    parameter int BURST_LEN = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         fifo_in,
    output logic                      fifo_in_valid,
    input  logic                      byte_rd,
    output logic [LVL_W-1:0]          level,
    output logic [2:0]                grant_id,
    output logic                      busy,
    output logic                      underflow_err
);

    localparam int BCW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

    logic [0:0]        state_q, state_d;
    logic [2:0]        grant_q, grant_d;
    logic [BCW-1:0]    burst_q, burst_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              uf_q, uf_d;
    logic [DATA_W-1:0] fifo_in_q, fifo_in_d;
    logic              fifo_vld_q, fifo_vld_d;

    logic [NUM_REQ-1:0] gnt_oh;
    logic [DATA_W-1:0]  gnt_dat;
    logic               gnt_vld;
    logic               hs;
    logic               pick_found;
    logic [2:0]         pick_idx;

    always_comb begin
        gnt_oh  = '0;
        gnt_dat = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt_oh[i] = (grant_q == 3'(i));
            if (grant_q == 3'(i)) begin
                gnt_dat = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Ready comes only from registered state so it never depends on req_valid.
    assign req_ready = (state_q == ST_XFER && level_q < DEPTH_L) ? gnt_oh : '0;
    assign gnt_vld   = |(req_valid & gnt_oh);
    assign hs        = |(req_valid & req_ready);

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = grant_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pick_found && req_valid[i] && i == (int'(grant_q) + k) % NUM_REQ) begin
                    pick_found = 1'b1;
                    pick_idx   = 3'(i);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        burst_d = burst_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    burst_d = '0;
                    state_d = ST_XFER;
                end
            end
            default: begin
                if (hs) begin
                    burst_d = burst_q + BCW'(1);
                    if (burst_q == BCW'(BURST_LEN - 1)) begin
                        state_d = ST_IDLE;
                    end
                end else if (!gnt_vld) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        level_d    = level_q;
        uf_d       = uf_q;
        fifo_in_d  = fifo_in_q;
        fifo_vld_d = hs;
        if (hs) begin
            fifo_in_d = gnt_dat;
        end
        if (hs && !byte_rd) begin
            level_d = level_q + LVL_W'(1);
        end else if (!hs && byte_rd && level_q != '0) begin
            level_d = level_q - LVL_W'(1);
        end
        if (byte_rd && level_q == '0) begin
            uf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= 3'(NUM_REQ - 1);
            burst_q    <= '0;
            level_q    <= '0;
            uf_q       <= 1'b0;
            fifo_in_q  <= '0;
            fifo_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            burst_q    <= burst_d;
            level_q    <= level_d;
            uf_q       <= uf_d;
            fifo_in_q  <= fifo_in_d;
            fifo_vld_q <= fifo_vld_d;
        end
    end

    assign fifo_in       = fifo_in_q;
    assign fifo_in_valid = fifo_vld_q;
    assign level         = level_q;
    assign grant_id      = grant_q;
    assign busy          = (state_q == ST_XFER);
    assign underflow_err = uf_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: per-producer byte queues, a transaction-level arbitration model,
// and an output monitor popping expected writes from a scoreboard queue.
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 8;
    localparam int DEPTH     = 32;
    localparam int LVL_W     = 6;
    localparam int BURST_LEN = 4;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [NUM_REQ*DATA_W-1:0] req_data = '0;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]         fifo_in;
    logic                      fifo_in_valid;
    logic                      byte_rd = 1'b0;
    logic [LVL_W-1:0]          level;
    logic [2:0]                grant_id;
    logic                      busy;
    logic                      underflow_err;

    fifo_wr_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .DEPTH(DEPTH), .LVL_W(LVL_W), .BURST_LEN(BURST_LEN)
    ) dut (
        .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid), .req_ready(req_ready),
        .fifo_in(fifo_in), .fifo_in_valid(fifo_in_valid), .byte_rd(byte_rd), .level(level),
        .grant_id(grant_id), .busy(busy), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [7:0]  dat;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] src_q[NUM_REQ][$];
    logic [NUM_REQ-1:0] en_mask = '0;
    int total = 0;
    int bad = 0;
    int n_wr = 0;

    // Reference model state: who holds the port, bytes used in this grant, credits in use.
    bit         m_busy = 1'b0;
    int         m_g = NUM_REQ - 1;
    int         m_cnt = 0;
    int         m_lvl = 0;
    bit         m_uf = 1'b0;
    logic [7:0] m_last = 8'h00;
    int         dut_log[$];
    logic       prev_busy = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic void drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i] = en_mask[i] && (src_q[i].size() > 0);
            req_data[i*DATA_W +: DATA_W] = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
        end
    endfunction

    function automatic bit pred_hs();
        return m_busy && (m_lvl < DEPTH) && req_valid[m_g] && !rst;
    endfunction

    function automatic void model_reset();
        m_busy = 1'b0;
        m_g    = NUM_REQ - 1;
        m_cnt  = 0;
        m_lvl  = 0;
        m_uf   = 1'b0;
    endfunction

    task automatic step();
        logic [NUM_REQ-1:0] er;
        bit hs;
        bit found;
        int nidx;
        @(negedge clk);
        er = '0;
        if (m_busy && m_lvl < DEPTH) er[m_g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(er));
        chk("level", 64'(level), 64'(m_lvl));
        chk("grant_id", 64'(grant_id), 64'(m_g));
        chk("busy", 64'(busy), 64'(m_busy));
        chk("underflow_err", 64'(underflow_err), 64'(m_uf));
        if (busy === 1'b1 && prev_busy !== 1'b1) dut_log.push_back(int'(grant_id));
        prev_busy = busy;
        if (rst) begin
            model_reset();
        end else begin
            hs = m_busy && (m_lvl < DEPTH) && req_valid[m_g];
            if (hs) begin
                exp_q.push_back('{due: cyc + 1, dat: src_q[m_g][0]});
                void'(src_q[m_g].pop_front());
                m_cnt++;
                if (m_cnt == BURST_LEN) m_busy = 1'b0;
            end else if (m_busy && !req_valid[m_g]) begin
                m_busy = 1'b0;
            end else if (!m_busy && req_valid != '0) begin
                found = 1'b0;
                nidx = m_g;
                for (int k = 1; k <= NUM_REQ; k++) begin
                    if (!found && req_valid[(m_g + k) % NUM_REQ]) begin
                        found = 1'b1;
                        nidx = (m_g + k) % NUM_REQ;
                    end
                end
                m_g = nidx;
                m_busy = 1'b1;
                m_cnt = 0;
            end
            if (byte_rd && m_lvl == 0) m_uf = 1'b1;
            if (hs && !byte_rd) m_lvl++;
            else if (!hs && byte_rd && m_lvl > 0) m_lvl--;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en_mask = '0;
        byte_rd = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Checks the idle/reset output values one negedge later without stepping the model.
    task automatic chk_reset_vals(input string pfx);
        @(negedge clk);
        chk({pfx, "_busy"}, 64'(busy), 64'd0);
        chk({pfx, "_fifo_in_valid"}, 64'(fifo_in_valid), 64'd0);
        chk({pfx, "_level"}, 64'(level), 64'd0);
        chk({pfx, "_grant_id"}, 64'(grant_id), 64'(NUM_REQ - 1));
        chk({pfx, "_req_ready"}, 64'(req_ready), 64'd0);
        chk({pfx, "_underflow"}, 64'(underflow_err), 64'd0);
        prev_busy = busy;
        @(posedge clk);
        #1;
    endtask

    // Output monitor: every registered write must match the oldest outstanding handshake.
    initial begin
        bit was_rst;
        exp_t e;
        forever begin
            @(posedge clk);
            was_rst = rst;
            @(negedge clk);
            if (was_rst) m_last = 8'h00;
            if (fifo_in_valid === 1'b1) begin
                n_wr++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: fifo_in_valid=1 data=%0h required no write (cycle %0d)", fifo_in, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_cycle", 64'(cyc), 64'(e.due));
                    chk("fifo_in", 64'(fifo_in), 64'(e.dat));
                    m_last = e.dat;
                end
            end else begin
                if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                    chk("fifo_in_valid", 64'(fifo_in_valid), 64'd1);
                    void'(exp_q.pop_front());
                end
                chk("fifo_in_hold", 64'(fifo_in), 64'(m_last));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bit done;
        bit hit;
        int exp_order[5];

        do_reset();
        chk_reset_vals("reset");

        // Single producer: six bytes, two grants (4 + 2).
        base = n_wr;
        for (int b = 0; b < 6; b++) src_q[0].push_back(8'hA1 + 8'(b));
        en_mask = 4'b0001;
        for (int c = 0; c < 12; c++) begin
            drive();
            step();
        end
        chk("single_writes", 64'(n_wr - base), 64'd6);
        chk("single_level", 64'(level), 64'd6);
        chk("single_grant", 64'(grant_id), 64'd0);

        // Round robin with all four producers continuously valid; fills to exactly DEPTH.
        do_reset();
        dut_log.delete();
        for (int i = 0; i < NUM_REQ; i++)
            for (int b = 0; b < 8; b++) src_q[i].push_back(8'($urandom));
        en_mask = 4'b1111;
        for (int c = 0; c < 45; c++) begin
            drive();
            step();
        end
        exp_order = '{0, 1, 2, 3, 0};
        chk("rr_grants", 64'(dut_log.size() >= 5), 64'd1);
        for (int k = 0; k < 5; k++)
            if (k < dut_log.size()) chk("rr_order", 64'(dut_log[k]), 64'(exp_order[k]));
        chk("rr_level", 64'(level), 64'(DEPTH));

        // Credit stall at full level, then release by a single pop.
        for (int b = 0; b < 3; b++) src_q[1].push_back(8'h50 + 8'(b));
        en_mask = 4'b0010;
        for (int c = 0; c < 5; c++) begin
            drive();
            step();
        end
        chk("stall_ready", 64'(req_ready), 64'd0);
        chk("stall_busy", 64'(busy), 64'd1);
        chk("stall_grant", 64'(grant_id), 64'd1);
        drive();
        byte_rd = 1'b1;
        step();
        byte_rd = 1'b0;
        chk("stall_rd_level", 64'(level), 64'(DEPTH - 1));
        chk("stall_rd_ready", 64'(req_ready), 64'b0010);
        drive();
        step();
        chk("stall_refill_level", 64'(level), 64'(DEPTH));
        chk("stall_refill_ready", 64'(req_ready), 64'd0);
        for (int c = 0; c < 300; c++) begin
            drive();
            byte_rd = (m_lvl > 0);
            step();
            if (m_lvl == 0 && !m_busy && src_q[1].size() == 0) break;
        end
        byte_rd = 1'b0;
        chk("drain_level", 64'(level), 64'd0);

        // Handshake and pop in the same cycle at level 10.
        do_reset();
        for (int b = 0; b < 11; b++) src_q[2].push_back(8'($urandom));
        en_mask = 4'b0100;
        done = 1'b0;
        for (int c = 0; c < 30; c++) begin
            drive();
            byte_rd = (!done && m_lvl == 10 && pred_hs());
            hit = byte_rd;
            if (byte_rd) done = 1'b1;
            step();
            byte_rd = 1'b0;
            if (hit) chk("simul_level", 64'(level), 64'd10);
        end
        chk("simul_final_level", 64'(level), 64'd10);

        // Pop at level 0 sets a sticky error cleared only by reset.
        do_reset();
        drive();
        byte_rd = 1'b1;
        step();
        byte_rd = 1'b0;
        chk("uf_set", 64'(underflow_err), 64'd1);
        chk("uf_level", 64'(level), 64'd0);
        for (int c = 0; c < 20; c++) step();
        chk("uf_sticky", 64'(underflow_err), 64'd1);
        do_reset();
        chk("uf_cleared", 64'(underflow_err), 64'd0);

        // Reset during the second handshake of a grant to producer 2.
        for (int b = 0; b < 4; b++) src_q[2].push_back(8'hC0 + 8'(b));
        en_mask = 4'b0100;
        for (int c = 0; c < 10; c++) begin
            drive();
            if (pred_hs() && m_cnt == 1) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                break;
            end
            step();
        end
        en_mask = '0;
        src_q[2].delete();
        drive();
        chk_reset_vals("midburst");

        // Randomised traffic with random pops.
        do_reset();
        for (int c = 0; c < 1600; c++) begin
            for (int i = 0; i < NUM_REQ; i++)
                if (src_q[i].size() < 4 && $urandom_range(3) == 0)
                    for (int b = 0; b < 6; b++) src_q[i].push_back(8'($urandom));
            en_mask = 4'($urandom);
            drive();
            byte_rd = (m_lvl > 0) && ($urandom_range(c < 800 ? 2 : 1) == 0);
            step();
        end
        en_mask = '0;
        byte_rd = 1'b0;
        drive();
        for (int c = 0; c < 5; c++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the byte write port of the serialising FIFO (fifo_in / fifo_in_valid) among NUM_REQ byte producers.
- Tracks FIFO occupancy with a credit counter, so no write is issued into a full FIFO.
- Sits directly upstream of the FIFO. The downstream serialiser pulses byte_rd once for each byte it pops.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width.
- DEPTH, 32, FIFO capacity in bytes; must match the FIFO buffer length.
- LVL_W, 6, occupancy counter width; must satisfy 2**LVL_W > DEPTH.
- BURST_LEN, 4, maximum handshakes per grant (>=1).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- req_data  in  NUM_REQ*DATA_W  requester i data at bits [i*DATA_W +: DATA_W].
- req_valid  in  NUM_REQ  requester i has a byte.
- req_ready  out  NUM_REQ  arbiter accepts requester i's byte this cycle.
- fifo_in  out  DATA_W  registered write data to the FIFO.
- fifo_in_valid  out  1  registered write strobe to the FIFO.
- byte_rd  in  1  one-cycle pulse: the FIFO popped one byte.
- level  out  LVL_W  current credit-tracked occupancy.
- grant_id  out  3  index of the current or last granted requester.
- busy  out  1  high while the state is XFER.
- underflow_err  out  1  sticky flag: byte_rd arrived while level == 0.

Behaviour:
- Reset values (synchronous, on any clk edge with rst=1, including mid-burst):
  - state=IDLE, fifo_in=0, fifo_in_valid=0, level=0, grant_id=NUM_REQ-1, burst_cnt=0, underflow_err=0, req_ready=0.
  - An in-flight registered write is dropped.
- State machine (2 states):
  - IDLE: if any req_valid, select the first asserted index scanning from grant_id+1 upward modulo NUM_REQ. Load grant_id, clear burst_cnt, go to XFER. No handshake happens in IDLE, so each new grant costs a one-cycle bubble.
  - XFER, handshake cycle: req_ready[grant_id] = (level < DEPTH). All other ready bits are 0, and ready is decoded from registers only. A handshake is req_valid[g] & req_ready[g]. On a handshake, burst_cnt increments; if burst_cnt == BURST_LEN-1, go to IDLE.
  - XFER, no handshake because req_valid[g] is low: go to IDLE.
  - XFER, no handshake because of credit stall (level == DEPTH, valid high): stay in XFER with the grant held.
- Write path:
  - A handshake in cycle t produces fifo_in = req_data[g] and fifo_in_valid = 1 in cycle t+1, i.e. 1-cycle latency.
  - Otherwise fifo_in_valid = 0 and fifo_in holds its last value.
- Credit counter, updated at the handshake edge:
  - handshake only: level+1.
  - byte_rd only with level > 0: level-1.
  - both in the same cycle: level unchanged.
  - byte_rd with level == 0: level stays 0 and underflow_err is set; only rst clears it.
- The level < DEPTH check makes overflow impossible. level never exceeds DEPTH.
- A byte_rd in the same cycle as a credit stall does not release the stall until the next cycle, because ready is registered-derived.
- grant_id persists after returning to IDLE and acts as the round-robin pointer.
- busy = (state == XFER).

Test Plan:
- Single requester: req_valid=4'b0001, 6 bytes 0xA1..0xA6, no byte_rd.
  - Expect: bubble, 4 writes A1..A4, bubble, A5, A6.
  - Expect: fifo_in_valid exactly one cycle after each handshake, level=6, grant_id=0.
- Round robin: all four valid continuously, BURST_LEN=4.
  - Expect grant order 0,1,2,3,0 with 4 bytes per grant.
  - Expect no req_ready on a non-granted index at any cycle.
- Credit stall: fill to level=32 with no byte_rd.
  - Expect req_ready low and the grant held.
  - Pulse byte_rd once: level goes to 31, ready reasserts next cycle, one more byte is written, level returns to 32.
- Simultaneous write and read: at level=10, handshake and byte_rd in the same cycle.
  - Expect level stays 10 and fifo_in_valid=1 next cycle.
- Underflow: byte_rd at level=0.
  - Expect level=0 and underflow_err=1, still 1 after 20 idle cycles, cleared only by rst.
- Mid-burst reset: assert rst during the 2nd handshake of a grant to requester 2.
  - Expect next cycle: state IDLE, fifo_in_valid=0, level=0, grant_id=3, req_ready all 0.
